// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
//
// A producer writes a full frame of hex nibbles and decimal points over a
// valid/ready port into a pending buffer. The pending frame is copied into the
// active buffer only when the scan wraps from the last digit back to digit 0,
// so a frame is never shown half old and half new. Each digit slot is a BLANK
// gap (all selects off, against ghosting) followed by a SHOW dwell. During
// SHOW a 3-bit PWM counter gates the digit for brightness control.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   wr_valid    producer has new frame data
//   wr_ready    pending buffer empty; a write is accepted on wr_valid & wr_ready
//   wr_data     nibble i = wr_data[4i+3:4i] drives digit i
//   wr_dp       decimal point per digit
//   digit_en    live per-digit enable mask
//   bright      brightness 0..7, sampled live
//   seg_out     segments {g,f,e,d,c,b,a}, active-high, registered
//   dp_out      decimal point, active-high, registered
//   an_out      one-hot digit select, active-high, registered
//   frame_tick  one-cycle pulse marking the frame wrap, registered

module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 10000,
  parameter int unsigned BLANK_CYCLES = 100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [2:0]              bright,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int unsigned SlotW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [SlotW-1:0] SlotLast  = SlotW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } state_e;

  // Segment encoding for one hex digit, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       pwm_q, pwm_d;
  logic             wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBlank;
      slot_q  <= '0;
      timer_q <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      timer_q <= timer_d;
      pwm_q   <= pwm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    timer_d = timer_q + CNT_W'(1);
    pwm_d   = pwm_q;
    wrap    = 1'b0;
    unique case (state_q)
      StBlank: begin
        if (timer_q == BlankLast) begin
          state_d = StShow;
          timer_d = '0;
          pwm_d   = '0;
        end
      end
      StShow: begin
        pwm_d = pwm_q + 3'd1;
        if (timer_q == DwellLast) begin
          state_d = StBlank;
          timer_d = '0;
          if (slot_q == SlotLast) begin
            slot_d = '0;
            wrap   = 1'b1;
          end else begin
            slot_d = slot_q + SlotW'(1);
          end
        end
      end
      default: begin
        state_d = StBlank;
        timer_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double buffer and write handshake
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic                    pend_full_q;
  logic                    accept;

  assign wr_ready = ~pend_full_q;
  assign accept   = wr_valid & ~pend_full_q;

  // Accept and commit are mutually exclusive: accept needs the pending buffer
  // empty, commit needs it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_full_q <= 1'b0;
    end else begin
      if (wrap && pend_full_q) begin
        act_data_q  <= pend_data_q;
        act_dp_q    <= pend_dp_q;
        pend_full_q <= 1'b0;
      end else if (accept) begin
        pend_data_q <= wr_data;
        pend_dp_q   <= wr_dp;
        pend_full_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage, registered one cycle behind the sequencer
  // ---------------------------------------------------------------------------
  logic [3:0]            cur_nib;
  logic                  lit;
  logic [6:0]            seg_d, seg_q;
  logic                  dp_d, dp_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic                  tick_q;

  always_comb begin
    cur_nib = act_data_q[{slot_q, 2'b00} +: 4];
    // pwm < bright+1 without widening: pwm <= bright.
    lit     = (state_q == StShow) && digit_en[slot_q] && (pwm_q <= bright);
    seg_d   = '0;
    dp_d    = 1'b0;
    an_d    = '0;
    if (lit) begin
      seg_d = hex7(cur_nib);
      dp_d  = act_dp_q[slot_q];
      an_d  = NUM_DIGITS'(1) << slot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q  <= '0;
      dp_q   <= 1'b0;
      an_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= wrap;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with NUM_DIGITS=4, DWELL=8, BLANK=2.
// A frame-position reference model predicts every registered output per cycle;
// predictions are queued when stimulus is driven and compared after the edge.

module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  digit_en;
  logic [2:0]  bright;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .digit_en  (digit_en),
    .bright    (bright),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {an[3:0], seg[6:0], dp, tick, ready}
  typedef logic [13:0] obs_t;
  obs_t sb[$];

  // Reference model state
  int          m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_actdp, m_penddp;
  logic        m_pfull;
  int          cyc = 0;

  function automatic logic [6:0] hex_ref(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[v];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // One clock: predict, push, clock, pop, compare.
  task automatic step();
    obs_t e;
    int   pos, slot;
    logic lt;
    e = '0;
    if (rst) begin
      e[0]     = 1'b1;
      m_t      = 0;
      m_act    = '0;
      m_actdp  = '0;
      m_pend   = '0;
      m_penddp = '0;
      m_pfull  = 1'b0;
    end else begin
      pos  = m_t % SLOT;
      slot = (m_t / SLOT) % N;
      lt   = (pos >= BL) && digit_en[slot] && ((pos - BL) % 8 <= int'(bright));
      if (lt) begin
        e[13:10] = 4'(1 << slot);
        e[9:3]   = hex_ref(m_act[slot*4 +: 4]);
        e[2]     = m_actdp[slot];
      end
      e[1] = (m_t % FRAME == FRAME - 1);
      if ((m_t % FRAME == FRAME - 1) && m_pfull) begin
        m_act   = m_pend;
        m_actdp = m_penddp;
        m_pfull = 1'b0;
      end else if (wr_valid && !m_pfull) begin
        m_pend   = wr_data;
        m_penddp = wr_dp;
        m_pfull  = 1'b1;
      end
      e[0] = !m_pfull;
      m_t++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("outputs", {18'd0, an_out, seg_out, dp_out, frame_tick, wr_ready}, {18'd0, e});
  endtask

  task automatic wait_tick(input string name);
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (!frame_tick && i < 200);
    if (!frame_tick) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no frame_tick within 200 cycles, got 0 expected 1", name);
    end
  endtask

  task automatic measure_period(input string name);
    int p;
    p = 0;
    do begin
      step();
      p++;
    end while (!frame_tick && p < 200);
    chk(name, p, FRAME);
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [2:0]  br;
    int          cycles;
  } phase_t;

  phase_t tbl [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit_cnt, bad_cnt;

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_dp    = '0;
    digit_en = 4'hF;
    bright   = 3'd7;

    // Reset, then idle scan of the cleared buffer
    repeat (2) step();
    chk("reset_outputs", {an_out, seg_out, dp_out, frame_tick}, 13'd0);
    chk("reset_ready", wr_ready, 1);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_slot0_an", an_out, 4'b0001);
    chk("idle_slot0_seg", seg_out, 7'h3F);
    wait_tick("first_tick");
    measure_period("idle_tick_period");

    // Single write, committed at the next wrap
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    wr_dp    = 4'b0001;
    step();
    wr_valid = 1'b0;
    chk("ready_drop", wr_ready, 0);
    wait_tick("commit_tick");
    chk("ready_after_commit", wr_ready, 1);
    repeat (3) step();
    chk("w1_slot0_seg", seg_out, 7'h66);
    chk("w1_slot0_dp", dp_out, 1);
    chk("w1_slot0_an", an_out, 4'b0001);
    repeat (SLOT) step();
    chk("w1_slot1_seg", seg_out, 7'h4F);
    chk("w1_slot1_dp", dp_out, 0);
    repeat (SLOT) step();
    chk("w1_slot2_seg", seg_out, 7'h5B);
    repeat (SLOT) step();
    chk("w1_slot3_seg", seg_out, 7'h06);

    // Write accepted, then a second write held off until the wrap
    wr_valid = 1'b1;
    wr_data  = 16'hABCD;
    wr_dp    = 4'b1000;
    step();
    chk("w2_ready_drop", wr_ready, 0);
    wr_data = 16'h5678;
    wr_dp   = 4'b0110;
    lit_cnt = 0;
    do begin
      step();
      lit_cnt++;
    end while (!wr_ready && lit_cnt < 200);
    chk("w3_held_until_wrap", frame_tick, 1);
    step();
    wr_valid = 1'b0;
    chk("w3_accepted", wr_ready, 0);
    repeat (2) step();
    chk("w2_first_frame_seg", seg_out, 7'h5E);
    wait_tick("w3_commit_tick");
    repeat (3) step();
    chk("w3_second_frame_seg", seg_out, 7'h7F);

    // Brightness duty
    bright = 3'd0;
    wait_tick("bright0_tick");
    lit_cnt = 0;
    repeat (FRAME) begin
      step();
      if (an_out != 0 && seg_out != 0) lit_cnt++;
    end
    chk("bright0_lit_cycles", lit_cnt, N * 1);
    bright = 3'd3;
    wait_tick("bright3_tick");
    lit_cnt = 0;
    repeat (FRAME) begin
      step();
      if (an_out != 0) lit_cnt++;
    end
    chk("bright3_lit_cycles", lit_cnt, N * 4);

    // Digit mask
    bright   = 3'd7;
    digit_en = 4'b1010;
    wait_tick("mask_tick");
    lit_cnt = 0;
    bad_cnt = 0;
    repeat (2 * FRAME) begin
      step();
      if ((an_out & 4'b0101) != 0) bad_cnt++;
      if ((an_out & 4'b1010) != 0) lit_cnt++;
    end
    chk("mask_disabled_never_on", bad_cnt, 0);
    chk("mask_enabled_cycles", lit_cnt, 2 * 2 * DW);
    measure_period("mask_tick_period");

    // Reset mid-SHOW with pending data
    digit_en = 4'hF;
    wr_valid = 1'b1;
    wr_data  = 16'hEF09;
    wr_dp    = 4'hF;
    step();
    wr_valid = 1'b0;
    repeat (13) step();
    chk("pre_reset_showing", an_out, 4'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_outputs", {an_out, seg_out, dp_out, frame_tick}, 13'd0);
    chk("midreset_ready", wr_ready, 1);
    bad_cnt = 0;
    repeat (2 * FRAME + 5) begin
      step();
      if (seg_out != 0 && seg_out != 7'h3F) bad_cnt++;
      if (dp_out) bad_cnt++;
    end
    chk("old_pending_never_shown", bad_cnt, 0);

    // Table-driven phases checked cycle by cycle against the model
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF,    3'd7, 2};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 4'hF,    3'd7, 45};
    tbl[2] = '{1'b0, 1'b1, 16'h9A5C, 4'b0101, 4'hF,    3'd7, 1};
    tbl[3] = '{1'b0, 1'b0, 16'h9A5C, 4'b0101, 4'b0101, 3'd5, 60};
    tbl[4] = '{1'b0, 1'b1, 16'h0F3E, 4'b1111, 4'b1001, 3'd2, 50};
    tbl[5] = '{1'b0, 1'b0, 16'h0F3E, 4'b1111, 4'b0111, 3'd6, 50};
    tbl[6] = '{1'b0, 1'b1, 16'h7B21, 4'b0000, 4'hF,    3'd1, 3};
    tbl[7] = '{1'b0, 1'b0, 16'h7B21, 4'b0000, 4'hF,    3'd4, 90};
    tbl[8] = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'hF,    3'd7, 1};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 4'hF,    3'd7, 45};
    for (int p = 0; p < 10; p++) begin
      rst      = tbl[p].rst;
      wr_valid = tbl[p].valid;
      wr_data  = tbl[p].data;
      wr_dp    = tbl[p].dp;
      digit_en = tbl[p].en;
      bright   = tbl[p].br;
      for (int c = 0; c < tbl[p].cycles; c++) step();
      wr_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
